// File: rtl/bcd_seven_seg_scanner_pkg.sv
// Shared display constants and types for the multiplexed BCD seven-segment scanner.
// Segment patterns are active-low in {g,f,e,d,c,b,a} order.
package bcd_seven_seg_scanner_pkg;

  localparam int BCD_W   = 4;
  localparam int NUM_DIG = 4;
  localparam int SEG_W   = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // One complete display image: four digits plus their decimal points.
  typedef struct packed {
    logic [NUM_DIG-1:0]            dp;
    logic [NUM_DIG-1:0][BCD_W-1:0] dig;
  } disp_t;

  function automatic logic is_zero(input logic [BCD_W-1:0] d);
    return (d == '0);
  endfunction

endpackage

// File: rtl/bcd_seven_seg_scanner_dec.sv
// Combinational BCD to active-low seven-segment decoder; codes above 9 show a dash.
module bcd_to_seven_seg
  import bcd_seven_seg_scanner_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  output logic [SEG_W-1:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner with frame-synchronous double buffering
// and optional leading-zero blanking. Display outputs are registered (1-cycle latency).
module bcd_seven_seg_scanner
  import bcd_seven_seg_scanner_pkg::*;
#(
  parameter int DIV      = 50000,
  parameter bit BLANK_LZ = 1'b1
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [BCD_W-1:0] ones,
  input  logic [BCD_W-1:0] tens,
  input  logic [BCD_W-1:0] hundreds,
  input  logic [BCD_W-1:0] thousands,
  input  logic [3:0]       dp_en,
  output logic [3:0]       an,
  output logic [SEG_W-1:0] seg,
  output logic             dp,
  output logic             pending,
  output logic             frame_tick
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [PW-1:0]    r_presc;
  logic [1:0]       r_idx;
  disp_t            r_shadow;
  disp_t            r_disp;
  logic             r_pending;
  logic             r_frame_tick;
  logic [3:0]       r_an;
  logic [SEG_W-1:0] r_seg;
  logic             r_dp;

  logic             w_tick;
  logic             w_frame;
  disp_t            w_in;
  logic [3:0]       w_blank;
  logic [BCD_W-1:0] w_cur;
  logic [SEG_W-1:0] w_seg;

  assign w_tick  = (r_presc == PW'(DIV - 1));
  assign w_frame = w_tick && (r_idx == 2'd3);

  assign w_in.dp  = dp_en;
  assign w_in.dig = {thousands, hundreds, tens, ones};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_presc      <= w_tick ? '0 : r_presc + 1'b1;
      r_idx        <= w_tick ? r_idx + 2'd1 : r_idx;
      r_frame_tick <= w_frame;
    end
  end

  // A load on the boundary bypasses the shadow so it is never left pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow  <= '0;
      r_disp    <= '0;
      r_pending <= 1'b0;
    end else if (load && w_frame) begin
      r_disp    <= w_in;
      r_pending <= 1'b0;
    end else if (load) begin
      r_shadow  <= w_in;
      r_pending <= 1'b1;
    end else if (w_frame && r_pending) begin
      r_disp    <= r_shadow;
      r_pending <= 1'b0;
    end
  end

  // Blanking cascades down from thousands; invalid codes count as nonzero.
  assign w_blank[3] = BLANK_LZ && is_zero(r_disp.dig[3]);
  assign w_blank[2] = w_blank[3] && is_zero(r_disp.dig[2]);
  assign w_blank[1] = w_blank[2] && is_zero(r_disp.dig[1]);
  assign w_blank[0] = 1'b0;

  assign w_cur = r_disp.dig[r_idx];

  bcd_to_seven_seg u_dec (
    .i_bcd (w_cur),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else if (w_blank[r_idx]) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= w_seg;
      r_dp  <= ~r_disp.dp[r_idx];
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign pending    = r_pending;
  assign frame_tick = r_frame_tick;

endmodule

// File: doc/bcd_seven_seg_scanner.md
BCD_SEVEN_SEG_SCANNER -- requirements
Module: bcd_seven_seg_scanner

Interface
REQ-001 Parameter DIV, default 50000, SHALL set the clock cycles each digit is lit; legal range 2 and up.
REQ-002 Parameter BLANK_LZ, default 1, SHALL enable leading-zero blanking when 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 load  input  1  one-cycle strobe that captures the four digit inputs.
REQ-006 ones, tens, hundreds, thousands  input  4 each  BCD digits from the binary-to-BCD converter.
REQ-007 dp_en  input  4  decimal-point enable per digit, bit 0 = ones; sampled on load.
REQ-008 an  output  4  active-low digit enables, bit 0 = ones.
REQ-009 seg  output  7  active-low segments, order {g,f,e,d,c,b,a}.
REQ-010 dp  output  1  active-low decimal point.
REQ-011 pending  output  1  high while captured data waits for a frame boundary.
REQ-012 frame_tick  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 The prescaler SHALL count 0..DIV-1 and wrap; its wrap cycle is the digit tick.
REQ-014 On each digit tick, the 2-bit scan index SHALL advance 0->1->2->3->0; index 0 = ones, 3 = thousands.
REQ-015 The frame boundary is the digit tick that moves the index 3->0; frame_tick SHALL be high on the cycle after that tick.
REQ-016 load SHALL copy the digit inputs and dp_en into a shadow register and set pending.
REQ-017 At a frame boundary with pending set, the shadow SHALL move to the display register and pending SHALL clear.
REQ-018 If load coincides with a frame boundary, the new inputs SHALL go straight to the display register and pending SHALL end that cycle at 0.
REQ-019 A load while pending is set SHALL overwrite the shadow; only the newest value is displayed.
REQ-020 an, seg and dp SHALL be registered, reflecting the index and display register of the previous cycle; latency is 1 cycle.
REQ-021 Decode, active-low: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex); digit values 10-15 SHALL show a dash, 3F.
REQ-022 With BLANK_LZ=1: thousands blanks if 0; hundreds blanks if thousands and hundreds are both 0; tens blanks if the upper three are 0; ones never blanks.
REQ-023 An invalid (>9) digit counts as nonzero for blanking.
REQ-024 A blanked slot SHALL drive an=4'b1111, seg=7F, dp=1 for its full period.
REQ-025 A non-blanked slot SHALL drive exactly one an bit low, and dp low iff its dp_en bit is set.

Reset
REQ-026 While rst_n is low at a clock edge, the following SHALL return to their reset values:
- prescaler=0, index=0, shadow=0, display=0, pending=0;
- an=4'b1111, seg=7F, dp=1, frame_tick=0.
REQ-027 Reset asserted mid-frame or mid-pending SHALL discard all data; no partial frame completes.
REQ-028 On the first edge after release, the outputs SHALL be an=4'b1110 and seg=40.

Structure
REQ-029 Segment pattern constants (digits 0-9, DASH, BLANK) SHALL live in the shared display package/include, alongside the BCD digit width constant.
REQ-030 The decoder SHALL be a combinational sub-module, bcd_to_seven_seg (4-bit in, 7-bit active-low out); scan, shadow and blanking logic stays in the top module.

Verification (DIV=4)
REQ-031 Reset: hold rst_n low 3 cycles -> an=1111, seg=7F, dp=1, pending=0, frame_tick=0.
REQ-032 Display 1234: load 1234 -> pending high until the first frame boundary, then this sequence, each state 4 cycles, with frame_tick every 16 cycles:
- an=1110, seg=19;
- an=1101, seg=30;
- an=1011, seg=24;
- an=0111, seg=79.
REQ-033 Leading-zero blanking: load 0007 -> only an=1110 with seg=78 ever asserted; the other three slots show an=1111. Load 0000 -> ones shows 40, the rest blank.
REQ-034 Invalid digit: load thousands=0, hundreds=C, tens=0, ones=5 -> the hundreds slot shows 3F; tens shows 40 (not blanked); thousands is blanked.
REQ-035 Load and frame boundary: pulse load on the 3->0 tick cycle -> the new digits appear in the next slot 0 and pending is never seen high. Two loads in one frame -> only the second value is displayed.
REQ-036 Reset mid-frame: assert rst_n low mid-frame while pending=1 -> reset values on the next edge; after release, 0 is shown in the ones slot.
